// File: rtl/reg_skid_buf_if.sv
// Valid/ready handshake bundle for the two-entry register slice.
// slave is the slice itself; master is the producer/reader side.
interface reg_skid_buf_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  i_valid;
    logic                  o_ready;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  o_valid;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] o_data;
    logic [1:0]            o_level;

    modport slave (
        input  i_valid,
        input  i_data,
        input  i_ready,
        output o_ready,
        output o_valid,
        output o_data,
        output o_level
    );

    modport master (
        output i_valid,
        output i_data,
        output i_ready,
        input  o_ready,
        input  o_valid,
        input  o_data,
        input  o_level
    );
endinterface

// File: rtl/reg_skid_buf.sv
// Two-entry valid/ready register slice; every output decodes from flops.
// main drives o_data, skid catches the word accepted while main is stalled.
module reg_skid_buf #(
    parameter int DATA_WIDTH = 32
) (
    input  logic           i_clk,
    input  logic           i_rst,
    reg_skid_buf_if.slave  bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] main_d;
    logic [DATA_WIDTH-1:0] skid_q;
    logic [DATA_WIDTH-1:0] skid_d;
    logic                  wr;
    logic                  rd;

    assign bus.o_valid = (state_q != EMPTY);
    assign bus.o_ready = (state_q != FULL);
    assign bus.o_data  = main_q;

    always_comb begin
        bus.o_level = 2'd0;
        unique case (state_q)
            BUSY:    bus.o_level = 2'd1;
            FULL:    bus.o_level = 2'd2;
            default: bus.o_level = 2'd0;
        endcase
    end

    assign wr = bus.i_valid & bus.o_ready;
    assign rd = bus.o_valid & bus.i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (wr) begin
                    main_d  = bus.i_data;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (wr && rd) begin
                    main_d = bus.i_data;
                end else if (wr) begin
                    skid_d  = bus.i_data;
                    state_d = FULL;
                end else if (rd) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // write cannot fire here since o_ready is low
                if (rd) begin
                    main_d  = skid_q;
                    state_d = BUSY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end
endmodule

// File: tb/tb_reg_skid_buf.sv
// Bench for reg_skid_buf: directed scenarios then random traffic,
// all checked against a queue-based model of a two-deep FIFO.
module tb_reg_skid_buf;
    logic clk = 1'b0;
    logic rst = 1'b1;

    reg_skid_buf_if #(.DATA_WIDTH(32)) bus ();

    reg_skid_buf #(.DATA_WIDTH(32)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int          n_vec  = 0;
    int          n_bad  = 0;
    logic [31:0] q[$];
    logic [31:0] stale  = '0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // FIFO of depth 2; o_data shows the last popped word when empty
    task automatic model_edge(input bit r_st, input bit v,
                              input logic [31:0] d, input bit r);
        bit can_w;
        bit can_r;
        if (r_st) begin
            q.delete();
            stale = '0;
        end else begin
            can_w = v && (q.size() < 2);
            can_r = r && (q.size() > 0);
            if (can_r) stale = q.pop_front();
            if (can_w) q.push_back(d);
        end
    endtask

    task automatic check_outs(input string tag);
        logic [31:0] exp_d;
        exp_d = (q.size() > 0) ? q[0] : stale;
        check({tag, ".valid"}, 32'(bus.o_valid), 32'(q.size() > 0));
        check({tag, ".ready"}, 32'(bus.o_ready), 32'(q.size() < 2));
        check({tag, ".level"}, 32'(bus.o_level), 32'(q.size()));
        check({tag, ".data"},  bus.o_data, exp_d);
    endtask

    task automatic cyc(input string tag, input bit r_st, input bit v,
                       input logic [31:0] d, input bit r);
        rst         = r_st;
        bus.i_valid = v;
        bus.i_data  = d;
        bus.i_ready = r;
        @(posedge clk);
        model_edge(r_st, v, d, r);
        @(negedge clk);
        check_outs(tag);
    endtask

    initial begin
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_ready = 1'b0;
        @(negedge clk);

        cyc("rst0", 1, 1, 32'hDEADBEEF, 0);
        cyc("rst1", 1, 1, 32'hDEADBEEF, 0);
        check("rst_data_zero", bus.o_data, 32'h0);

        for (int i = 1; i <= 8; i++)
            cyc("stream", 0, 1, 32'(i), 1);
        check("stream_last", bus.o_data, 32'h8);
        cyc("stream_drain", 0, 0, 32'h0, 1);

        cyc("fill_a", 0, 1, 32'hAAAA0000, 0);
        cyc("fill_b", 0, 1, 32'hBBBB0000, 0);
        check("fill_head", bus.o_data, 32'hAAAA0000);
        check("fill_lvl2", 32'(bus.o_level), 32'd2);
        cyc("drain1", 0, 0, 32'h0, 1);
        check("drain1_head", bus.o_data, 32'hBBBB0000);
        cyc("drain2", 0, 0, 32'h0, 1);

        cyc("hold_load", 0, 1, 32'h12345678, 0);
        for (int i = 0; i < 5; i++)
            cyc("hold", 0, 0, (i % 2) ? 32'hFFFFFFFF : 32'h0, 0);
        check("hold_data", bus.o_data, 32'h12345678);
        cyc("hold_drain", 0, 0, 32'h0, 1);

        cyc("sim_load", 0, 1, 32'h1, 0);
        cyc("sim_wr_rd", 0, 1, 32'h2, 1);
        check("sim_data", bus.o_data, 32'h2);
        cyc("sim_drain", 0, 0, 32'h0, 1);

        cyc("mid_a", 0, 1, 32'h11110000, 0);
        cyc("mid_b", 0, 1, 32'h22220000, 0);
        cyc("mid_rst", 1, 1, 32'h33330000, 1);
        check("mid_rst_lvl", 32'(bus.o_level), 32'd0);
        cyc("mid_wr", 0, 1, 32'hCAFE0001, 0);
        check("mid_wr_data", bus.o_data, 32'hCAFE0001);
        cyc("mid_rd", 0, 0, 32'h0, 1);

        for (int i = 0; i < 400; i++)
            cyc("rand", ($urandom_range(0, 49) == 0),
                1'($urandom), $urandom, 1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end
endmodule
